scale_matrix_seq: RTL and testbench

Parametrised, multi-cycle successor to the combinational-per-clock matrix scaler. It multiplies every element of a DIM x DIM matrix by a scalar and processes LANES elements per clock, trading latency for multiplier count. It adds signed/unsigned operation, saturate/wrap selection, an overflow flag and a start/busy/done handshake. It sits in the math unit behind instruction decode and uses the same flattened matrix bus format as the other math modules.

---
 rtl/scale_matrix_seq.sv | 148 ++++++++++++++
 tb/tb_scale_matrix_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scale_matrix_seq.sv
// Multi-cycle matrix-by-scalar scaler: LANES elements per clock, with
// signed/unsigned, saturate/wrap, overflow flag and start/busy/done.
//
// Ports:
//   clk, reset (async, active-high)
//   start      : request, sampled in IDLE only
//   matrix     : DIM*DIM*EW row-major, (0,0) in LSBs
//   scalar     : SW-bit multiplier
//   signed_en  : 1 = two's complement operands
//   sat_en     : 1 = saturate, 0 = wrap to low EW bits
//   m_out      : result matrix, same packing as matrix
//   busy, done : handshake (done is a one-cycle pulse)
//   overflow   : some element of last op did not fit in EW bits
module scale_matrix_seq #(
  parameter int DIM   = 4,
  parameter int EW    = 16,
  parameter int SW    = 8,
  parameter int LANES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DIM*DIM*EW-1:0]   matrix,
  input  logic [SW-1:0]           scalar,
  input  logic                    signed_en,
  input  logic                    sat_en,
  output logic [DIM*DIM*EW-1:0]   m_out,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  localparam int N  = DIM * DIM;
  localparam int MW = N * EW;
  localparam int IW = $clog2(N);
  // Two guard bits keep every signed/unsigned product exact.
  localparam int PW = EW + SW + 2;

  localparam logic signed [PW-1:0] MAXU =
    {{(PW-EW){1'b0}}, {EW{1'b1}}};
  localparam logic signed [PW-1:0] MAXS =
    {{(PW-EW+1){1'b0}}, {(EW-1){1'b1}}};
  localparam logic signed [PW-1:0] MINS =
    {{(PW-EW+1){1'b1}}, {(EW-1){1'b0}}};

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  generate
    if ((N % LANES) != 0 || SW > EW) begin : g_bad_params
      $error("scale_matrix_seq: LANES must divide DIM*DIM, SW <= EW");
    end
  endgenerate

  logic [0:0]    state;
  logic [MW-1:0] mat_q;
  logic [MW-1:0] res_q;
  logic [MW-1:0] res_nxt;
  logic [SW-1:0] scal_q;
  logic          sgn_q;
  logic          sat_q;
  logic [IW-1:0] idx;
  logic          ovf_acc;
  logic          grp_ovf;
  logic          last;

  assign last = (int'(idx) + LANES) == N;

  always_comb begin
    logic signed [PW-1:0] ea;
    logic signed [PW-1:0] sa;
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] hi;
    logic signed [PW-1:0] lo;
    logic [EW-1:0]        e;
    logic [EW-1:0]        r;
    int                   k;
    res_nxt = res_q;
    grp_ovf = 1'b0;
    hi = sgn_q ? MAXS : MAXU;
    lo = sgn_q ? MINS : '0;
    sa = sgn_q ? {{(PW-SW){scal_q[SW-1]}}, scal_q}
               : {{(PW-SW){1'b0}}, scal_q};
    for (int l = 0; l < LANES; l++) begin
      k  = int'(idx) + l;
      e  = mat_q[k*EW +: EW];
      ea = sgn_q ? {{(PW-EW){e[EW-1]}}, e}
                 : {{(PW-EW){1'b0}}, e};
      p  = ea * sa;
      r  = p[EW-1:0];
      if (p > hi) begin
        grp_ovf = 1'b1;
        if (sat_q) r = hi[EW-1:0];
      end else if (p < lo) begin
        grp_ovf = 1'b1;
        if (sat_q) r = lo[EW-1:0];
      end
      res_nxt[k*EW +: EW] = r;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      m_out    <= '0;
      mat_q    <= '0;
      res_q    <= '0;
      scal_q   <= '0;
      sgn_q    <= 1'b0;
      sat_q    <= 1'b0;
      idx      <= '0;
      ovf_acc  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mat_q   <= matrix;
            scal_q  <= scalar;
            sgn_q   <= signed_en;
            sat_q   <= sat_en;
            idx     <= '0;
            ovf_acc <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          res_q   <= res_nxt;
          ovf_acc <= ovf_acc | grp_ovf;
          idx     <= idx + IW'(LANES);
          if (last) begin
            m_out    <= res_nxt;
            overflow <= ovf_acc | grp_ovf;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scale_matrix_seq.sv
// Scoreboard bench for scale_matrix_seq: a LANES=1 and a LANES=4 instance
// share data inputs; a negedge monitor checks each done against a queue.
module tb_scale_matrix_seq;

  localparam int MW = 256;

  typedef struct {
    logic [MW-1:0] m;
    logic          ovf;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start1 = 1'b0;
  logic          start4 = 1'b0;
  logic [MW-1:0] mat = '0;
  logic [7:0]    scal = '0;
  logic          sgn = 1'b0;
  logic          sat = 1'b0;
  logic [MW-1:0] m1, m4;
  logic          busy1, busy4, done1, done4, ovf1, ovf4;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q1[$];
  exp_t q4[$];

  scale_matrix_seq #(.DIM(4), .EW(16), .SW(8), .LANES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .matrix(mat),
    .scalar(scal), .signed_en(sgn), .sat_en(sat), .m_out(m1),
    .busy(busy1), .done(done1), .overflow(ovf1)
  );

  scale_matrix_seq #(.DIM(4), .EW(16), .SW(8), .LANES(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .matrix(mat),
    .scalar(scal), .signed_en(sgn), .sat_en(sat), .m_out(m4),
    .busy(busy4), .done(done4), .overflow(ovf4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [MW-1:0] act,
                     input logic [MW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_done", 1'b1, 1'b0);
      end else begin
        e = q1.pop_front();
        chk("dut1_m_out", m1, e.m);
        chk("dut1_overflow", ovf1, e.ovf);
        chk("dut1_latency", cyc, e.due);
      end
    end
    if (done4) begin
      if (q4.size() == 0) begin
        chk("dut4_unexpected_done", 1'b1, 1'b0);
      end else begin
        e = q4.pop_front();
        chk("dut4_m_out", m4, e.m);
        chk("dut4_overflow", ovf4, e.ovf);
        chk("dut4_latency", cyc, e.due);
      end
    end
  end

  // Pulse start for one edge and log the expected response.
  task automatic issue(input bit four, input logic [MW-1:0] em,
                       input logic eo);
    exp_t e;
    if (four) start4 = 1'b1;
    else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
    e.m   = em;
    e.ovf = eo;
    e.due = cyc + (four ? 4 : 16);
    if (four) q4.push_back(e);
    else q1.push_back(e);
    chk(four ? "dut4_busy_after_start" : "dut1_busy_after_start",
        four ? busy4 : busy1, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() != 0 || q4.size() != 0) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", (q1.size() != 0 || q4.size() != 0), 1'b0);
  endtask

  logic [MW-1:0] em;
  logic [MW-1:0] ea;
  int            acc;

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #7;
    chk("reset_m_out", m1, '0);
    chk("reset_busy", busy1, 1'b0);
    chk("reset_done", done1, 1'b0);
    chk("reset_overflow", ovf1, 1'b0);
    #10 reset = 1'b0;
    @(negedge clk);

    // 1: elements 1..16, scalar 3, unsigned wrap
    for (int i = 0; i < 16; i++) begin
      mat[i*16 +: 16] = 16'(i + 1);
      em[i*16 +: 16]  = 16'((i + 1) * 3);
    end
    scal = 8'd3; sgn = 1'b0; sat = 1'b0;
    issue(1'b0, em, 1'b0);
    acc = cyc;
    repeat (15) @(posedge clk);
    #1;
    chk("t1_busy_before_last", busy1, 1'b1);
    chk("t1_done_before_last", done1, 1'b0);
    @(posedge clk);
    #1;
    chk("t1_busy_after_last", busy1, 1'b0);
    chk("t1_done_after_last", done1, 1'b1);
    drain();

    // 2: unsigned 0x4000*8 saturate then wrap
    for (int i = 0; i < 16; i++) begin
      mat[i*16 +: 16] = 16'(i + 1);
      em[i*16 +: 16]  = 16'((i + 1) * 8);
    end
    mat[15:0] = 16'h4000;
    scal = 8'd8; sat = 1'b1;
    em[15:0] = 16'hFFFF;
    issue(1'b0, em, 1'b1);
    drain();
    sat = 1'b0;
    em[15:0] = 16'h0000;
    issue(1'b0, em, 1'b1);
    drain();

    // 3: signed saturate cases
    sgn = 1'b1; sat = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mat[i*16 +: 16] = 16'h0001;
      em[i*16 +: 16]  = 16'h0005;
    end
    mat[15:0] = 16'hFFFE; em[15:0] = 16'hFFF6;
    scal = 8'h05;
    issue(1'b0, em, 1'b0);
    drain();
    for (int i = 0; i < 16; i++) begin
      mat[i*16 +: 16] = 16'h0002;
      em[i*16 +: 16]  = 16'h0008;
    end
    mat[15:0]  = 16'h7000; em[15:0]  = 16'h7FFF;
    mat[31:16] = 16'h9000; em[31:16] = 16'h8000;
    mat[47:32] = 16'hFFFF; em[47:32] = 16'hFFFC;
    scal = 8'h04;
    issue(1'b0, em, 1'b1);
    drain();
    for (int i = 0; i < 16; i++) begin
      mat[i*16 +: 16] = 16'h0000;
      em[i*16 +: 16]  = 16'h0000;
    end
    mat[15:0]  = 16'h8000; em[15:0]  = 16'h7FFF;
    mat[31:16] = 16'h0003; em[31:16] = 16'hFFFD;
    scal = 8'hFF;
    issue(1'b0, em, 1'b1);
    drain();
    // signed wrap: 0x7000*4 = 0x1C000 -> 0xC000
    sat = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mat[i*16 +: 16] = 16'h0001;
      em[i*16 +: 16]  = 16'h0004;
    end
    mat[15:0] = 16'h7000; em[15:0] = 16'hC000;
    scal = 8'h04;
    issue(1'b0, em, 1'b1);
    drain();

    // 4: LANES=4 instance, 0x0010 * 0x10
    sgn = 1'b0; sat = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mat[i*16 +: 16] = 16'h0010;
      em[i*16 +: 16]  = 16'h0100;
    end
    scal = 8'h10;
    issue(1'b1, em, 1'b0);
    drain();

    // 5: start during RUN ignored, then back-to-back at done
    for (int i = 0; i < 16; i++) begin
      mat[i*16 +: 16] = 16'(i + 1);
      em[i*16 +: 16]  = 16'((i + 1) * 2);
      ea[i*16 +: 16]  = 16'h003F;
    end
    scal = 8'd2; sgn = 1'b0; sat = 1'b0;
    issue(1'b0, em, 1'b0);
    acc = cyc;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) mat[i*16 +: 16] = 16'h0007;
    scal = 8'd9; sgn = 1'b1; sat = 1'b1;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    chk("t5_busy_during_ignored_start", busy1, 1'b1);
    sgn = 1'b0; sat = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("t5_done_cycle", done1, 1'b1);
    issue(1'b0, ea, 1'b0);
    drain();

    // 6: async reset mid-operation
    for (int i = 0; i < 16; i++) begin
      mat[i*16 +: 16] = 16'(i + 1);
      em[i*16 +: 16]  = 16'((i + 1) * 3);
    end
    scal = 8'd3;
    issue(1'b0, em, 1'b0);
    repeat (7) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_m_out_reset", m1, '0);
    chk("t6_busy_reset", busy1, 1'b0);
    chk("t6_overflow_reset", ovf1, 1'b0);
    q1.delete();
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("t6_m_out_after_abort", m1, '0);
    issue(1'b0, em, 1'b0);
    drain();
    chk("t6_m_out_hold", m1, em);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
